// File: rtl/input_capture_pkg.sv
// Shared constants for the calculator input front end: control-word width,
// button indices and the C_reg field layout.
package input_capture_pkg;

  localparam int C_W   = 10;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;

  localparam int HEX_MODE_HI = 9;
  localparam int HEX_MODE_LO = 8;
  localparam int HEX_SHOW_HI = 7;
  localparam int HEX_SHOW_LO = 6;
  localparam int LED_SHOW_HI = 5;
  localparam int LED_SHOW_LO = 4;
  localparam int CARRY_IN    = 3;
  localparam int ALU_OP_HI   = 2;
  localparam int ALU_OP_LO   = 0;

  typedef struct packed {
    logic [1:0] hex_mode;
    logic [1:0] hex_show;
    logic [1:0] led_show;
    logic       carry_in;
    logic [2:0] alu_op;
  } c_fields_t;

endpackage

// File: rtl/input_capture_if.sv
// Board-side inputs and captured register outputs of input_capture.
// master drives switches/buttons, slave is the capture block.
interface input_capture_if #(parameter int N = 4);
  import input_capture_pkg::*;

  logic [C_W-1:0] SWITCH;
  logic           B0;
  logic           B1;
  logic           B2;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [C_W-1:0] c_reg;
  logic [2:0]     load;
  logic [2:0]     btn_db;

  modport master (
    output SWITCH, B0, B1, B2,
    input  a_reg, b_reg, c_reg, load, btn_db
  );

  modport slave (
    input  SWITCH, B0, B1, B2,
    output a_reg, b_reg, c_reg, load, btn_db
  );
endinterface

// File: rtl/input_capture_debounce.sv
// Per-button 2-flop synchronizer plus counting debouncer; fall is a
// combinational pulse on the edge where a press (1->0) is accepted.
module debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, b_s_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      b_s_q   <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      b_s_q   <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept = (b_s_q != level_q) && (cnt_q == CNT_MAX);

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (b_s_q == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      level_d = b_s_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level = level_q;
  assign fall  = accept & level_q;
endmodule

// File: rtl/input_capture.sv
// Calculator front end: debounced buttons capture synchronized switches
// into A/B/C. Optional INPUT_CAPTURE_CLEAR_EN: all-buttons-down clears all.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  input_capture_if.slave  bus
);
  logic [C_W-1:0] sw_m_q, sw_s_q;
  logic [2:0]     raw, level, fall, idle;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [C_W-1:0] c_q, c_d;
  logic [2:0]     load_q, load_d;

  assign raw[BTN_A] = bus.B0;
  assign raw[BTN_B] = bus.B1;
  assign raw[BTN_C] = bus.B2;

  for (genvar i = 0; i < 3; i++) begin : g_db
    debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (level[i]),
      .fall  (fall[i])
    );
  end

  // Buttons that stay released through this edge; a press only counts when
  // every other button is idle in this sense.
  assign idle = level & ~fall;

  always_comb begin
    load_d = '0;
    for (int i = 0; i < 3; i++)
      load_d[i] = fall[i] & (&(idle | (3'b001 << i)));
`ifdef INPUT_CAPTURE_CLEAR_EN
    if ((|fall) && (idle == 3'b000)) load_d = 3'b111;
`endif
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (load_d == 3'b111) begin
      a_d = '0;
      b_d = '0;
      c_d = '0;
    end else begin
      if (load_d[BTN_A]) a_d = sw_s_q[N-1:0];
      if (load_d[BTN_B]) b_d = sw_s_q[N-1:0];
      if (load_d[BTN_C]) c_d = c_fields_t'(sw_s_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m_q <= '0;
      sw_s_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      load_q <= '0;
    end else begin
      sw_m_q <= bus.SWITCH;
      sw_s_q <= sw_m_q;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      load_q <= load_d;
    end
  end

  assign bus.a_reg  = a_q;
  assign bus.b_reg  = b_q;
  assign bus.c_reg  = c_q;
  assign bus.load   = load_q;
  assign bus.btn_db = level;
endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture with DEB_CYCLES=4, N=4.
module tb_input_capture;
  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  typedef struct {
    logic [2:0]   load;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [9:0]   c;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [N-1:0] mdl_a, mdl_b;
  logic [9:0]   mdl_c;

  input_capture_if #(.N(N)) bus();

  input_capture #(.N(N), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [2:0] ld, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [9:0] c);
    exp_t e;
    e.load = ld; e.a = a; e.b = b; e.c = c; e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled at the following falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.load !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: load=%b a=%h b=%h c=%h at edge %0d, no capture expected",
                 bus.load, bus.a_reg, bus.b_reg, bus.c_reg, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.load !== e.load || bus.a_reg !== e.a || bus.b_reg !== e.b ||
            bus.c_reg !== e.c || cyc != e.cyc) begin
          errors++;
          $display("FAIL capture: got load=%b a=%h b=%h c=%h edge=%0d, want load=%b a=%h b=%h c=%h edge=%0d",
                   bus.load, bus.a_reg, bus.b_reg, bus.c_reg, cyc, e.load, e.a, e.b, e.c, e.cyc);
        end
        mdl_a = e.a; mdl_b = e.b; mdl_c = e.c;
      end
    end else begin
      if (sb.size() != 0) begin
        checks++;
        if (sb[0].cyc <= cyc) begin
          errors++;
          $display("FAIL missed_capture: load=000 at edge %0d, want load=%b at edge %0d",
                   cyc, sb[0].load, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
      checks++;
      if (bus.a_reg !== mdl_a || bus.b_reg !== mdl_b || bus.c_reg !== mdl_c) begin
        errors++;
        $display("FAIL hold: a=%h b=%h c=%h, want a=%h b=%h c=%h at edge %0d",
                 bus.a_reg, bus.b_reg, bus.c_reg, mdl_a, mdl_b, mdl_c, cyc);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected captures outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_db(input string name, input logic [2:0] want);
    checks++;
    if (bus.btn_db !== want) begin
      errors++;
      $display("FAIL %s_btn_db: btn_db=%b, want %b", name, bus.btn_db, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.SWITCH = 10'h3FF; bus.B0 = 1'b1; bus.B1 = 1'b1; bus.B2 = 1'b1;
    mdl_a = '0; mdl_b = '0; mdl_c = '0;
    run(3);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_db("reset", 3'b111);
    end
    drain("reset");
  endtask

  task automatic test_capture_a();
    bus.SWITCH = 10'h2B5;
    bus.B0 = 1'b0;
    push(3'b001, 4'h5, mdl_b, mdl_c);
    run(10);
    check_db("press_a", 3'b110);
    bus.B0 = 1'b1;
    run(10);
    check_db("release_a", 3'b111);
    drain("capture_a");
  endtask

  task automatic test_bounce_b();
    bus.B1 = 1'b0;
    run(3);
    bus.B1 = 1'b1;
    run(10);
    check_db("bounce_b", 3'b111);
    bus.SWITCH = 10'h3C7;
    bus.B1 = 1'b0;
    push(3'b010, mdl_a, 4'h7, mdl_c);
    run(10);
    bus.B1 = 1'b1;
    run(10);
    drain("bounce_b");
  endtask

  task automatic test_blocked_and_hold();
    bus.SWITCH = 10'h155;
    bus.B0 = 1'b0;
    push(3'b001, 4'h5, mdl_b, mdl_c);
    run(10);
    bus.B2 = 1'b0;
    run(10);
    check_db("both_low", 3'b010);
    bus.B0 = 1'b1;
    run(10);
    check_db("b2_still_low", 3'b011);
    bus.B2 = 1'b1;
    run(10);
    bus.B2 = 1'b0;
    push(3'b100, mdl_a, mdl_b, 10'h155);
    run(10);
    bus.SWITCH = 10'h0AA;
    run(20);
    bus.B2 = 1'b1;
    run(10);
    drain("blocked_hold");
  endtask

  task automatic test_simultaneous();
    bus.SWITCH = 10'h00F;
    bus.B0 = 1'b0; bus.B1 = 1'b0;
    run(10);
    check_db("simul_ab", 3'b100);
    bus.B0 = 1'b1; bus.B1 = 1'b1;
    run(10);
    bus.B0 = 1'b0; bus.B1 = 1'b0; bus.B2 = 1'b0;
`ifdef INPUT_CAPTURE_CLEAR_EN
    push(3'b111, '0, '0, '0);
`endif
    run(10);
    check_db("simul_abc", 3'b000);
    bus.B0 = 1'b1; bus.B1 = 1'b1; bus.B2 = 1'b1;
    run(10);
    drain("simultaneous");
  endtask

  task automatic test_reset_mid();
    bus.SWITCH = 10'h2F0;
    bus.B2 = 1'b0;
    run(3);
    rst_n = 1'b0;
    mdl_a = '0; mdl_b = '0; mdl_c = '0;
    #1;
    checks++;
    if (bus.a_reg !== '0 || bus.b_reg !== '0 || bus.c_reg !== '0 ||
        bus.load !== 3'b000 || bus.btn_db !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_async: a=%h b=%h c=%h load=%b btn_db=%b, want all 0 and btn_db=111",
               bus.a_reg, bus.b_reg, bus.c_reg, bus.load, bus.btn_db);
    end
    run(2);
    rst_n = 1'b1;
    push(3'b100, '0, '0, 10'h2F0);
    run(12);
    bus.B2 = 1'b1;
    run(10);
    drain("reset_mid");
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_capture_a();
    test_bounce_b();
    test_blocked_and_hold();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
